// File: rtl/mem_arbiter.sv
// mem_arbiter: two-state CPU/DMA arbiter for a shared memory bus with FRAM wait states.
// DMA has priority; the CPU breaks through after MAX_DMA_BURST consecutive DMA grants.
module mem_arbiter #(
  parameter logic [15:0] FRAM_START    = 16'h4400,
  parameter logic [15:0] FRAM_LAST     = 16'hFFFF,
  parameter int          MAX_DMA_BURST = 4
) (
  input  logic        MCLK,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        dma_req,
  input  logic [15:0] cpu_MAB,
  input  logic [15:0] dma_MAB,
  input  logic [15:0] cpu_MDBwrite,
  input  logic [15:0] dma_MDBwrite,
  input  logic        cpu_MW,
  input  logic        dma_MW,
  input  logic        cpu_BW,
  input  logic        dma_BW,
  input  logic [2:0]  NWAITS,
  input  logic [15:0] MDBread,
  output logic [15:0] MAB,
  output logic [15:0] MDBwrite,
  output logic        MW,
  output logic        BW,
  output logic        cpu_ready,
  output logic        dma_ready,
  output logic [15:0] cpu_MDBread,
  output logic [15:0] dma_MDBread
);
  localparam int SW = $clog2(MAX_DMA_BURST + 1);
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [15:0]   mab_q, mab_d, mdbw_q, mdbw_d;
  logic          mw_q, mw_d, bw_q, bw_d;
  logic          acc, done, arb, grant_dma, in_fram;
  logic [15:0]   win_mab;
  logic [16:0]   lo_diff, hi_diff;

  // Range test by borrow bits so a full-range FRAM_LAST does not fold to a constant compare.
  always_comb begin
    acc       = state_q == ACCESS;
    done      = acc && cnt_q == 3'd0;
    arb       = (!acc || done) && (cpu_req || dma_req);
    grant_dma = dma_req && !(cpu_req && streak_q == SW'(MAX_DMA_BURST));
    win_mab   = grant_dma ? dma_MAB : cpu_MAB;
    lo_diff   = {1'b0, win_mab} - {1'b0, FRAM_START};
    hi_diff   = {1'b0, FRAM_LAST} - {1'b0, win_mab};
    in_fram   = !lo_diff[16] && !hi_diff[16];
    state_d   = state_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    streak_d  = streak_q;
    mab_d     = mab_q;
    mdbw_d    = mdbw_q;
    mw_d      = mw_q;
    bw_d      = bw_q;
    if (arb) begin
      state_d  = ACCESS;
      owner_d  = grant_dma;
      mab_d    = win_mab;
      mdbw_d   = grant_dma ? dma_MDBwrite : cpu_MDBwrite;
      mw_d     = grant_dma ? dma_MW : cpu_MW;
      bw_d     = grant_dma ? dma_BW : cpu_BW;
      cnt_d    = in_fram ? NWAITS : 3'd0;
      streak_d = !(grant_dma && cpu_req) ? '0 :
                 streak_q == SW'(MAX_DMA_BURST) ? streak_q : streak_q + 1'b1;
    end else if (done) begin
      state_d = IDLE;
    end else if (acc) begin
      cnt_d = cnt_q - 3'd1;
    end
  end

  always_ff @(posedge MCLK) begin
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      cnt_q    <= '0;
      streak_q <= '0;
      mab_q    <= '0;
      mdbw_q   <= '0;
      mw_q     <= 1'b0;
      bw_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      streak_q <= streak_d;
      mab_q    <= mab_d;
      mdbw_q   <= mdbw_d;
      mw_q     <= mw_d;
      bw_q     <= bw_d;
    end
  end

  assign MAB         = acc ? mab_q : '0;
  assign MDBwrite    = acc ? mdbw_q : '0;
  assign BW          = acc && bw_q;
  assign MW          = done && mw_q;
  assign cpu_ready   = done && !owner_q;
  assign dma_ready   = done && owner_q;
  assign cpu_MDBread = cpu_ready ? MDBread : '0;
  assign dma_MDBread = dma_ready ? MDBread : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed transactions with a queue scoreboard checked by an independent monitor.
module tb_mem_arbiter;
  logic        MCLK = 0, reset = 1;
  logic        cpu_req = 0, dma_req = 0;
  logic [15:0] cpu_MAB = 0, dma_MAB = 0, cpu_MDBwrite = 0, dma_MDBwrite = 0;
  logic        cpu_MW = 0, dma_MW = 0, cpu_BW = 0, dma_BW = 0;
  logic [2:0]  NWAITS = 0;
  logic [15:0] MDBread, MAB, MDBwrite, cpu_MDBread, dma_MDBread;
  logic        MW, BW, cpu_ready, dma_ready;

  mem_arbiter dut (
    .MCLK(MCLK), .reset(reset), .cpu_req(cpu_req), .dma_req(dma_req),
    .cpu_MAB(cpu_MAB), .dma_MAB(dma_MAB), .cpu_MDBwrite(cpu_MDBwrite), .dma_MDBwrite(dma_MDBwrite),
    .cpu_MW(cpu_MW), .dma_MW(dma_MW), .cpu_BW(cpu_BW), .dma_BW(dma_BW), .NWAITS(NWAITS),
    .MDBread(MDBread), .MAB(MAB), .MDBwrite(MDBwrite), .MW(MW), .BW(BW),
    .cpu_ready(cpu_ready), .dma_ready(dma_ready), .cpu_MDBread(cpu_MDBread), .dma_MDBread(dma_MDBread)
  );

  always #5 MCLK = ~MCLK;
  assign MDBread = MAB ^ 16'hA5A5;

  typedef struct {logic dma; logic [15:0] addr; logic [15:0] wdata; logic we; logic bw; int lat;} exp_t;
  exp_t sb[$];
  int   checks = 0, errors = 0, cyc = 0, grant_cyc = 0;
  bit   busy = 0;

  always @(posedge MCLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per ready; tracks grant time to measure latency.
  initial begin : mon
    exp_t e;
    forever begin
      @(negedge MCLK);
      #1;
      if (MW) chk("mw_only_at_ready", 32'(cpu_ready | dma_ready), 1);
      if (cpu_ready || dma_ready) begin
        if (sb.size() == 0) chk("unexpected_ready", {cpu_ready, dma_ready}, 0);
        else begin
          e = sb.pop_front();
          chk("owner", dma_ready, e.dma);
          chk("both_ready", cpu_ready & dma_ready, 0);
          chk("MAB", MAB, e.addr);
          chk("MW", MW, e.we);
          chk("BW", BW, e.bw);
          if (e.we) chk("MDBwrite", MDBwrite, e.wdata);
          chk("owner_MDBread", e.dma ? dma_MDBread : cpu_MDBread, e.addr ^ 16'hA5A5);
          chk("other_MDBread", e.dma ? cpu_MDBread : dma_MDBread, 0);
          chk("latency", cyc - grant_cyc + 1, e.lat);
        end
      end
      if (reset) busy = 0;
      else if (!busy || cpu_ready || dma_ready) begin
        busy = cpu_req || dma_req;
        grant_cyc = cyc + 1;
      end
    end
  end

  task automatic idle_chk(input string tag);
    chk({tag, "_MAB"}, MAB, 0);
    chk({tag, "_MDBwrite"}, MDBwrite, 0);
    chk({tag, "_MW_BW"}, {MW, BW}, 0);
    chk({tag, "_ready"}, {cpu_ready, dma_ready}, 0);
  endtask

  task automatic xfer(input bit d, input logic [15:0] a, input bit w, input logic [15:0] wd,
                      input bit b, input logic [2:0] nw, input logic [2:0] nw_after,
                      input bit drop, input int lat);
    bit got;
    sb.push_back('{d, a, wd, w, b, lat});
    @(negedge MCLK);
    NWAITS = nw;
    if (d) begin dma_req = 1; dma_MAB = a; dma_MW = w; dma_MDBwrite = wd; dma_BW = b; end
    else   begin cpu_req = 1; cpu_MAB = a; cpu_MW = w; cpu_MDBwrite = wd; cpu_BW = b; end
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge MCLK);
      if (i == 0) begin
        NWAITS = nw_after;
        if (drop) begin cpu_req = 0; dma_req = 0; end
      end
      got = cpu_ready | dma_ready;
    end
    cpu_req = 0;
    dma_req = 0;
    chk("ready_seen", 32'(got), 1);
    @(negedge MCLK);
  endtask

  initial begin
    int  n;
    bit  saw;
    repeat (3) @(negedge MCLK);
    reset = 0;
    idle_chk("reset");
    // dma, addr, we, wdata, bw, nwaits, nwaits_after_grant, drop_early, latency
    xfer(0, 16'h1C00, 0, 16'h0000, 0, 3, 3, 0, 1);
    xfer(0, 16'h4400, 1, 16'hBEEF, 0, 3, 3, 0, 4);
    xfer(0, 16'h43FF, 0, 16'h0000, 0, 1, 1, 0, 1);
    xfer(1, 16'h4400, 0, 16'h0000, 0, 1, 1, 0, 2);
    xfer(0, 16'hFFFF, 1, 16'h00AA, 1, 1, 1, 0, 2);
    xfer(0, 16'h8000, 0, 16'h0000, 0, 2, 7, 0, 3);
    xfer(1, 16'h8002, 0, 16'h0000, 0, 7, 7, 0, 8);
    xfer(1, 16'h9000, 0, 16'h0000, 0, 3, 3, 1, 4);
    idle_chk("between");
    // Both requesters held: four DMA grants then one CPU grant, repeating
    for (int i = 0; i < 10; i++)
      if (i % 5 == 4) sb.push_back('{1'b0, 16'h1000, 16'h0000, 1'b0, 1'b0, 1});
      else            sb.push_back('{1'b1, 16'h2000, 16'h1234, 1'b1, 1'b1, 1});
    @(negedge MCLK);
    NWAITS = 3;
    cpu_MAB = 16'h1000; cpu_MW = 0; cpu_BW = 0;
    dma_MAB = 16'h2000; dma_MW = 1; dma_BW = 1; dma_MDBwrite = 16'h1234;
    cpu_req = 1; dma_req = 1;
    n = 0;
    for (int i = 0; i < 40 && n < 10; i++) begin
      @(negedge MCLK);
      if (cpu_ready | dma_ready) n++;
    end
    cpu_req = 0; dma_req = 0;
    chk("streak_grants", n, 10);
    repeat (2) @(negedge MCLK);
    // Reset in the second cycle of a wait-stated DMA write aborts it
    NWAITS = 5;
    dma_MAB = 16'h5000; dma_MW = 1; dma_BW = 0; dma_MDBwrite = 16'hCAFE;
    dma_req = 1;
    @(negedge MCLK);
    @(negedge MCLK);
    reset = 1;
    dma_req = 0;
    @(negedge MCLK);
    reset = 0;
    idle_chk("abort");
    saw = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge MCLK);
      saw = saw | MW | dma_ready | cpu_ready;
    end
    chk("abort_quiet", 32'(saw), 0);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter FRAM_START, default 16'h4400, lowest address of the wait-stated FRAM region.
REQ-002 Parameter FRAM_LAST, default 16'hFFFF, highest address (inclusive) of the wait-stated FRAM region.
REQ-003 Parameter MAX_DMA_BURST, default 4, number of consecutive DMA grants allowed while the CPU is waiting.
REQ-004 MCLK  in  1  system clock; all state changes on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 cpu_req, dma_req  in  1 each  access request, held high until the matching ready.
REQ-007 cpu_MAB, dma_MAB  in  16 each  requester address.
REQ-008 cpu_MDBwrite, dma_MDBwrite  in  16 each  requester write data.
REQ-009 cpu_MW, dma_MW, cpu_BW, dma_BW  in  1 each  requester write enable and byte select.
REQ-010 NWAITS  in  3  FRAM wait states, 0-7.
REQ-011 MDBread  in  16  shared memory read data.
REQ-012 MAB, MDBwrite  out  16 each  shared memory address and write data.
REQ-013 MW, BW  out  1 each  shared memory write strobe and byte select.
REQ-014 cpu_ready, dma_ready  out  1 each  access-complete pulse to the owner.
REQ-015 cpu_MDBread, dma_MDBread  out  16 each  read data returned to each requester.

Function
REQ-016 The FSM SHALL have two states, IDLE and ACCESS, plus an owner register (CPU/DMA), a 3-bit wait counter and a DMA-streak counter.
REQ-017 In IDLE: MAB=0, MDBwrite=0, MW=0, BW=0, both ready=0.
REQ-018 Arbitration SHALL occur at a rising edge in IDLE, or at the completing edge of an ACCESS, whenever any req is high.
REQ-019 Priority SHALL go to DMA; when both are requesting and streak==MAX_DMA_BURST, the CPU SHALL be granted instead.
REQ-020 Streak SHALL increment on each DMA grant made while cpu_req is high, saturate at MAX_DMA_BURST, and clear on any CPU grant or on a DMA grant made with cpu_req low.
REQ-021 On grant, the winner's MAB/MDBwrite/MW/BW SHALL be latched and the FSM SHALL enter ACCESS; the latched values drive MAB/MDBwrite/BW for the whole access.
REQ-022 The wait counter SHALL load NWAITS if FRAM_START<=latched MAB<=FRAM_LAST, else 0; NWAITS is sampled only at grant.
REQ-023 In ACCESS the counter SHALL decrement each cycle while nonzero; the cycle with counter==0 is the completion cycle.
REQ-024 MW SHALL equal the latched MW only in the completion cycle, so each write commits exactly once.
REQ-025 In the completion cycle the owner's ready SHALL be 1 and its MDBread output SHALL equal MDBread.
REQ-026 Non-owner ready SHALL be 0 and non-owner MDBread output SHALL be 16'h0000 at all times.
REQ-027 Latency: request granted at edge k SHALL complete (ready high) in the cycle after edge k+waits, i.e. waits+1 cycles.
REQ-028 At the completing edge, if any req is high (requester signals sampled after ready), the FSM SHALL re-arbitrate and stay in ACCESS with no idle cycle; otherwise it SHALL return to IDLE.
REQ-029 Deassertion of a req during its own ACCESS SHALL be ignored; the latched access completes.
REQ-030 Boundary addresses FRAM_START and FRAM_LAST SHALL be wait-stated; FRAM_START-1 SHALL not.

Reset
REQ-031 While reset is high at a rising edge: state=IDLE, owner=CPU, counter=0, streak=0, all latches=0.
REQ-032 Reset during ACCESS SHALL abort it: no MW pulse, no ready, on or after that edge.
REQ-033 Outputs SHALL match REQ-017 in the cycle after reset.

Verification
REQ-034 CPU read 16'h1C00, NWAITS=3 -> no waits; cpu_ready one cycle after grant, cpu_MDBread=MDBread.
REQ-035 CPU word write 16'h4400 data 16'hBEEF, NWAITS=3 -> MW high only in 4th ACCESS cycle; cpu_ready same cycle.
REQ-036 cpu_req and dma_req held continuously, non-FRAM addresses -> grants D,D,D,D,C,D,D,D,D,C, back-to-back, no idle cycles.
REQ-037 NWAITS changed 2->7 mid-access at 16'h8000 -> current access completes after 2 waits; next FRAM access uses 7.
REQ-038 Reset asserted in 2nd cycle of DMA write at 16'h5000, NWAITS=5 -> MW never asserted, dma_ready stays 0, IDLE outputs next cycle.
REQ-039 Address 16'h43FF vs 16'h4400, NWAITS=1 -> ready after 1 vs 2 ACCESS cycles.
